// File: rtl/rw_ctrl_seq.sv
// Round-robin requester arbiter that sequences one single-port memory access at a time.
// Define RW_CTRL_PARITY_EN to add read-parity checking (rsp_perr) and write parity (mem_wpar).
module rw_ctrl_seq #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 2,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [CH_W-1:0]          rsp_ch,
    output logic                     rsp_we,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     mem_cs,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
`ifdef RW_CTRL_PARITY_EN
    input  logic                     mem_rpar,
    output logic                     rsp_perr,
    output logic                     mem_wpar,
`endif
    output logic                     busy
);

    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    state_t              state_q;
    logic [CH_W-1:0]     ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                rsp_valid_q;
    logic                rsp_we_q;
    logic [CH_W-1:0]     rsp_ch_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                mem_cs_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                busy_q;
`ifdef RW_CTRL_PARITY_EN
    logic                perr_q;
    logic                wpar_q;
`endif

    logic                gnt_any_c;
    logic                gnt_we_c;
    logic [CH_W-1:0]     gnt_idx_c;
    logic [CH_W-1:0]     cand_c;
    logic [NUM_CH-1:0]   gnt_oh_c;
    logic [ADDR_W-1:0]   gnt_addr_c;
    logic [DATA_W-1:0]   gnt_wdata_c;
    logic [CH_W-1:0]     ptr_nxt_c;

    // First valid channel at or after the priority pointer, wrapping around.
    always_comb begin
        gnt_any_c   = 1'b0;
        gnt_we_c    = 1'b0;
        gnt_idx_c   = '0;
        cand_c      = '0;
        gnt_oh_c    = '0;
        gnt_addr_c  = '0;
        gnt_wdata_c = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand_c = CH_W'((32'(ptr_q) + k) % NUM_CH);
            if (!gnt_any_c && req_valid[cand_c]) begin
                gnt_any_c         = 1'b1;
                gnt_idx_c         = cand_c;
                gnt_oh_c[cand_c]  = 1'b1;
                gnt_we_c          = req_we[cand_c];
                gnt_addr_c        = req_addr[cand_c*ADDR_W +: ADDR_W];
                gnt_wdata_c       = req_wdata[cand_c*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_nxt_c = (32'(gnt_idx_c) == NUM_CH - 1) ? '0 : CH_W'(32'(gnt_idx_c) + 32'd1);

    // Acceptance is combinational and only offered while idle and out of reset.
    assign req_ready = (rst_n && state_q == S_IDLE) ? gnt_oh_c : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_ch_q    <= '0;
            rsp_rdata_q <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
`ifdef RW_CTRL_PARITY_EN
            perr_q      <= 1'b0;
            wpar_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_any_c) begin
                        state_q     <= S_ACCESS;
                        busy_q      <= 1'b1;
                        ptr_q       <= ptr_nxt_c;
                        mem_cs_q    <= 1'b1;
                        mem_we_q    <= gnt_we_c;
                        mem_addr_q  <= gnt_addr_c;
                        mem_wdata_q <= gnt_wdata_c;
                        rsp_ch_q    <= gnt_idx_c;
                        rsp_we_q    <= gnt_we_c;
                        rsp_rdata_q <= '0;
`ifdef RW_CTRL_PARITY_EN
                        perr_q      <= 1'b0;
                        wpar_q      <= ^gnt_wdata_c;
`endif
                    end
                end
                S_ACCESS: begin
                    mem_cs_q <= 1'b0;
                    if (mem_we_q) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q   <= CNT_W'(RD_LAT);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    // Last wait cycle: read data is valid on the memory bus now.
                    if (cnt_q == CNT_W'(1)) begin
                        rsp_rdata_q <= mem_rdata;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
`ifdef RW_CTRL_PARITY_EN
                        perr_q      <= (^mem_rdata) ^ mem_rpar;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_ch    = rsp_ch_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
`ifdef RW_CTRL_PARITY_EN
    assign rsp_perr  = perr_q;
    assign mem_wpar  = wpar_q;
`endif

endmodule

// File: tb/tb_rw_ctrl_seq.sv
// Bench for rw_ctrl_seq: transaction-level reference model plus directed and random stimulus.
// Build with RW_CTRL_PARITY_EN defined to also exercise the parity ports.
module tb_rw_ctrl_seq;

    localparam int unsigned NCH = 3;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 8;
    localparam int          RDL = 2;
    localparam int unsigned CHW = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [NCH-1:0]   req_valid;
    logic [NCH-1:0]   req_ready;
    logic [NCH-1:0]   req_we;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [CHW-1:0]   rsp_ch;
    logic             rsp_we;
    logic [DW-1:0]    rsp_rdata;
    logic             mem_cs;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;
    logic             busy;
`ifdef RW_CTRL_PARITY_EN
    logic             mem_rpar;
    logic             rsp_perr;
    logic             mem_wpar;
`endif

    rw_ctrl_seq #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ch(rsp_ch),
        .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef RW_CTRL_PARITY_EN
        .mem_rpar(mem_rpar), .rsp_perr(rsp_perr), .mem_wpar(mem_wpar),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: one transaction in flight, timed from its accept cycle.
    int            m_p;
    bit            m_have;
    int            m_acc;
    int            m_ch;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_lwe;
    logic [AW-1:0] m_laddr;
    logic [DW-1:0] m_lwdata;
    logic [DW-1:0] ref_mem [256];

    // Memory device on the DUT's memory port.
    logic [DW-1:0] dev_mem [256];
    int            rd_due = -100;
    logic [AW-1:0] rd_addr;
    bit            par_flip = 1'b0;
    bit            flip_at_due = 1'b0;

    always @(negedge clk) begin : model_blk
        logic [NCH-1:0] exp_ready;
        int             g;
        int             idx;
        bit             exp_rv;
        bit             exp_cs;
        logic [DW-1:0]  exp_rd;
        if (!rst_n) begin
            check("rst_req_ready", 32'(req_ready), 32'(0));
            check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            check("rst_rsp_ch",    32'(rsp_ch),    32'(0));
            check("rst_rsp_we",    32'(rsp_we),    32'(0));
            check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
            check("rst_mem_cs",    32'(mem_cs),    32'(0));
            check("rst_mem_we",    32'(mem_we),    32'(0));
            check("rst_mem_addr",  32'(mem_addr),  32'(0));
            check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
            check("rst_busy",      32'(busy),      32'(0));
`ifdef RW_CTRL_PARITY_EN
            check("rst_rsp_perr",  32'(rsp_perr),  32'(0));
            check("rst_mem_wpar",  32'(mem_wpar),  32'(0));
`endif
            m_p = 0; m_have = 1'b0; m_lwe = 1'b0; m_laddr = '0; m_lwdata = '0;
            rd_due = -100;
        end else begin
            exp_ready = '0;
            g = -1;
            if (!m_have) begin
                for (int k = 0; k < int'(NCH); k++) begin
                    idx = (m_p + k) % int'(NCH);
                    if (g < 0 && req_valid[CHW'(idx)]) g = idx;
                end
                if (g >= 0) exp_ready[CHW'(g)] = 1'b1;
            end
            exp_cs = m_have && (cyc == m_acc + 1);
            exp_rv = m_have && (cyc >= m_acc + 2 + (m_we ? 0 : RDL));
            if (exp_cs) begin
                m_lwe = m_we; m_laddr = m_addr; m_lwdata = m_wdata;
                if (m_we) ref_mem[m_addr] = m_wdata;
            end
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("busy",      32'(busy),      32'(m_have));
            check("mem_cs",    32'(mem_cs),    32'(exp_cs));
            check("mem_we",    32'(mem_we),    32'(m_lwe));
            check("mem_addr",  32'(mem_addr),  32'(m_laddr));
            check("mem_wdata", 32'(mem_wdata), 32'(m_lwdata));
`ifdef RW_CTRL_PARITY_EN
            check("mem_wpar",  32'(mem_wpar),  32'(^m_lwdata));
`endif
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv) begin
                exp_rd = m_we ? '0 : ref_mem[m_addr];
                check("rsp_ch",    32'(rsp_ch),    32'(m_ch));
                check("rsp_we",    32'(rsp_we),    32'(m_we));
                check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
`ifdef RW_CTRL_PARITY_EN
                check("rsp_perr",  32'(rsp_perr),  32'(!m_we && flip_at_due));
`endif
                if (rsp_ready) m_have = 1'b0;
            end else if (g >= 0) begin
                m_have  = 1'b1;
                m_acc   = cyc;
                m_ch    = g;
                m_we    = req_we[CHW'(g)];
                m_addr  = req_addr[g*AW +: AW];
                m_wdata = req_wdata[g*DW +: DW];
                m_p     = (g + 1) % int'(NCH);
            end
        end
        // Memory device: data appears RDL cycles after the select cycle, noise otherwise.
        if (rst_n && mem_cs) begin
            if (mem_we) dev_mem[mem_addr] = mem_wdata;
            else begin
                rd_due  = cyc + RDL;
                rd_addr = mem_addr;
            end
        end
        if (cyc == rd_due) begin
            mem_rdata   = dev_mem[rd_addr];
            flip_at_due = par_flip;
        end else begin
            mem_rdata = DW'($urandom);
        end
`ifdef RW_CTRL_PARITY_EN
        mem_rpar = (^mem_rdata) ^ par_flip;
`endif
    end

    task automatic set_req(input int ch, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[ch]           = 1'b1;
        req_we[ch]              = we;
        req_addr[ch*AW +: AW]   = a;
        req_wdata[ch*DW +: DW]  = d;
    endtask

    task automatic reset_dut();
        @(posedge clk); #3;
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
    endtask

    // Issue one command, wait for its response; returns in the rsp_valid cycle.
    task automatic do_cmd(input string name, input int ch, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int exp_lat, input logic [DW-1:0] exp_rd);
        int lat;
        bit got;
        @(posedge clk); #1;
        set_req(ch, we, a, d);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[ch]) got = 1'b1;
        end
        if (!got) begin
            check({name, "_accept"}, 32'(0), 32'(1));
            req_valid[ch] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[ch] = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
            else lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_ch"},      32'(rsp_ch), 32'(ch));
        check({name, "_we"},      32'(rsp_we), 32'(we));
        check({name, "_rdata"},   32'(rsp_rdata), 32'(exp_rd));
    endtask

    typedef struct {
        int            ch;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t           tbl [7];
    logic [NCH-1:0] grants [4];
    logic [NCH-1:0] exp_gr [4];
    int             ng;
    bit             got;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
        $fatal(1);
    end

    initial begin
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; mem_rdata = '0;
`ifdef RW_CTRL_PARITY_EN
        mem_rpar = 1'b0;
`endif
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        tbl[0] = '{0, 1'b1, 8'h12, 8'hA5, 2,       8'h00};
        tbl[1] = '{1, 1'b1, 8'h34, 8'h5C, 2,       8'h00};
        tbl[2] = '{1, 1'b0, 8'h34, 8'h00, 2 + RDL, 8'h5C};
        tbl[3] = '{0, 1'b0, 8'h12, 8'h00, 2 + RDL, 8'hA5};
        tbl[4] = '{2, 1'b1, 8'hFF, 8'h00, 2,       8'h00};
        tbl[5] = '{2, 1'b0, 8'hFF, 8'h00, 2 + RDL, 8'h00};
        tbl[6] = '{0, 1'b0, 8'h00, 8'h00, 2 + RDL, 8'h03};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            do_cmd($sformatf("vec%0d", i), tbl[i].ch, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                   tbl[i].lat, tbl[i].rdata);

        // Two channels contending: strict alternation starting from channel 0.
        reset_dut();
        exp_gr[0] = 3'b001; exp_gr[1] = 3'b010; exp_gr[2] = 3'b001; exp_gr[3] = 3'b010;
        @(posedge clk); #1;
        set_req(0, 1'b1, 8'h20, 8'h11);
        set_req(1, 1'b1, 8'h21, 8'h22);
        ng = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                grants[ng] = req_ready;
                ng++;
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        check("arb_count", 32'(ng), 32'(4));
        for (int i = 0; i < 4; i++)
            check($sformatf("arb_grant%0d", i), 32'(grants[i]), 32'(exp_gr[i]));
        repeat (4) @(posedge clk);

        // Response back-pressure: everything frozen, no acceptance while stalled.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(1, 1'b0, 8'h34, 8'h00);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1'b1;
        end
        check("stall_accept", 32'(got), 32'(1));
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        set_req(2, 1'b1, 8'h50, 8'h77);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 32'(1));
            check("stall_rsp_ch",    32'(rsp_ch),    32'(1));
            check("stall_rsp_rdata", 32'(rsp_rdata), 32'(8'h5C));
            check("stall_req_ready", 32'(req_ready), 32'(0));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_release_grant", 32'(req_ready), 32'(3'b100));
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        repeat (4) @(posedge clk);

        // Reset while waiting on read data: aborts silently, next read is normal.
        @(posedge clk); #1;
        set_req(0, 1'b0, 8'h12, 8'h00);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1'b1;
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #3;
        check("pre_rst_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("async_rst_busy",     32'(busy),      32'(0));
        check("async_rst_mem_cs",   32'(mem_cs),    32'(0));
        check("async_rst_mem_addr", 32'(mem_addr),  32'(0));
        check("async_rst_rsp",      32'(rsp_valid), 32'(0));
        @(negedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", 32'(rsp_valid), 32'(0));
        end
        do_cmd("post_rst_read", 0, 1'b0, 8'h12, 8'h00, 2 + RDL, 8'hA5);

`ifdef RW_CTRL_PARITY_EN
        do_cmd("par_wr", 1, 1'b1, 8'h40, 8'h03, 2, 8'h00);
        par_flip = 1'b1;
        do_cmd("par_rd_bad", 1, 1'b0, 8'h40, 8'h00, 2 + RDL, 8'h03);
        check("par_perr_set", 32'(rsp_perr), 32'(1));
        par_flip = 1'b0;
        do_cmd("par_rd_good", 1, 1'b0, 8'h40, 8'h00, 2 + RDL, 8'h03);
        check("par_perr_clr", 32'(rsp_perr), 32'(0));
`endif

        // Random traffic, including dropped requests and response back-pressure.
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            req_valid = NCH'($urandom);
            req_we    = NCH'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < int'(NCH); k++) begin
                req_addr[k*AW +: AW]  = AW'($urandom_range(0, 15));
                req_wdata[k*DW +: DW] = DW'($urandom);
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (20) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
